// File: rtl/pergate_compute_gen_pkg.sv
// Field constants (p = 2^61-1), gate-type encodings and modular add/sub helpers
// shared by the per-gate compute unit and its field multiplier.
package pergate_compute_gen_pkg;

   localparam int unsigned F_NBITS = 61;
   localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};
   // Fermat inverse exponent (p-2)
   localparam logic [F_NBITS-1:0] F_Q_P2_MI = F_Q - F_NBITS'(2);

   typedef logic [F_NBITS-1:0] fe_t;

   typedef enum logic [1:0] {
      GT_ADD  = 2'b00,
      GT_MUL  = 2'b01,
      GT_SUB  = 2'b10,
      GT_PASS = 2'b11
   } gate_type_e;

   // Per-round configuration latched when a round is accepted
   typedef struct packed {
      logic       precomp;
      gate_type_e gt;
      fe_t        vin1;
   } round_cfg_t;

   function automatic fe_t f_add_mod(input fe_t a, input fe_t b);
      logic [F_NBITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
      return s[F_NBITS-1:0];
   endfunction

   // A borrow out of the extended difference marks a negative result
   function automatic fe_t f_sub_mod(input fe_t a, input fe_t b);
      logic [F_NBITS:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[F_NBITS]) d = d + {1'b0, F_Q};
      return d[F_NBITS-1:0];
   endfunction

endpackage

// File: rtl/pergate_compute_gen_field_mul.sv
// Shared field multiplier mod 2^61-1: product captured on start, valid after mul_lat cycles.
module pergate_field_mul
   import pergate_compute_gen_pkg::*;
#(
   parameter int unsigned mul_lat = 2
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               abort,
   input  logic               start,
   input  logic [F_NBITS-1:0] a,
   input  logic [F_NBITS-1:0] b,
   output logic [F_NBITS-1:0] prod,
   output logic               valid
);

   localparam int unsigned CW = (mul_lat > 1) ? $clog2(mul_lat) : 1;

   logic [2*F_NBITS-1:0] w_full;
   logic [F_NBITS:0]     w_fold;
   logic [F_NBITS-1:0]   w_red;
   logic [CW-1:0]        r_cnt;
   logic                 r_valid;
   logic [F_NBITS-1:0]   r_prod;

   // Mersenne reduction: fold high half onto low half, one conditional subtract
   always_comb begin
      w_full = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
      w_fold = {1'b0, w_full[F_NBITS-1:0]} + {1'b0, w_full[2*F_NBITS-1:F_NBITS]};
      if (w_fold >= {1'b0, F_Q}) w_red = F_NBITS'(w_fold - {1'b0, F_Q});
      else                       w_red = w_fold[F_NBITS-1:0];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_prod  <= '0;
      end else if (abort) begin
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else if (start) begin
         r_prod  <= w_red;
         r_cnt   <= CW'(mul_lat - 1);
         r_valid <= (mul_lat == 1);
      end else if (r_cnt != '0) begin
         r_cnt   <= r_cnt - CW'(1);
         r_valid <= (r_cnt == CW'(1));
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign prod  = r_prod;
   assign valid = r_valid;

endmodule

// File: rtl/pergate_compute_gen.sv
// Per-gate sum-check compute unit: accumulates the wiring predicate and evaluates gate outputs.
// Optional sticky protocol-error flag enabled by PERGATE_COMPUTE_GEN_ERRFLAG_EN.
module pergate_compute_gen
   import pergate_compute_gen_pkg::*;
#(
   parameter int unsigned        nidbits = 9,
   parameter logic [nidbits-1:0] id_vec  = '0,
   parameter int unsigned        npoints = 3,
   parameter int unsigned        mul_lat = 2
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            en,
   input  logic                            restart,
   input  logic                            precomp,
   input  logic [1:0]                      gate_type,
   input  logic [F_NBITS-1:0]              tau,
   input  logic [F_NBITS-1:0]              m_tau_p1,
   input  logic [npoints-1:0][F_NBITS-1:0] vin0,
   input  logic [F_NBITS-1:0]              vin1,
   output logic                            ready,
   output logic                            ready_pulse,
   output logic                            done,
   output logic                            err,
   output logic [npoints-1:0][F_NBITS-1:0] gate_out
);

   localparam int unsigned RW = $clog2(nidbits + 1);
   localparam int unsigned KW = (npoints > 1) ? $clog2(npoints) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MUL_T = 3'd1;
   localparam logic [2:0] S_GFN   = 3'd2;
   localparam logic [2:0] S_OUT   = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   typedef logic [npoints-1:0][F_NBITS-1:0] vec_t;

   logic [2:0]         r_state, w_state_nxt;
   logic [KW-1:0]      r_k, w_k_nxt;
   logic [RW-1:0]      r_round, w_round_nxt;
   logic [F_NBITS-1:0] r_acc, w_acc_nxt;
   logic [F_NBITS-1:0] r_t, w_t_nxt;
   round_cfg_t         r_cfg, w_cfg_nxt;
   vec_t               r_vin0, w_vin0_nxt;
   vec_t               r_res, w_res_nxt;
   vec_t               r_gate_out, w_gate_out_nxt;
   logic               r_ready, w_ready_nxt;
   logic               r_pulse, w_pulse_nxt;
   logic               r_done, w_done_nxt;

   logic               w_mul_start_c, w_mul_abort_c, w_mul_valid, w_launch_c;
   logic [F_NBITS-1:0] w_mul_a_c, w_mul_b_c, w_mul_prod;
   logic [nidbits-1:0] w_id_sh;
   logic [F_NBITS-1:0] w_f, w_t_cur, w_v0_sel, w_gfn;
   logic [KW-1:0]      w_idx;
   logic               w_last;

   pergate_field_mul #(.mul_lat(mul_lat)) u_mul (
      .clk   (clk),
      .rstb  (rstb),
      .abort (w_mul_abort_c),
      .start (w_mul_start_c),
      .a     (w_mul_a_c),
      .b     (w_mul_b_c),
      .prod  (w_mul_prod),
      .valid (w_mul_valid)
   );

   // Factor select, current t, and gate function of the next point to launch
   always_comb begin
      w_id_sh = id_vec >> r_round;
      w_f     = w_id_sh[0] ? tau : m_tau_p1;
      w_t_cur = (r_state == S_MUL_T) ? w_mul_prod : r_t;
      w_last  = (r_k == KW'(npoints - 1));
      if ((r_state == S_MUL_T) || w_last) w_idx = '0;
      else                                 w_idx = r_k + KW'(1);
      w_v0_sel = r_vin0[w_idx];
      case (r_cfg.gt)
         GT_ADD:  w_gfn = f_add_mod(w_v0_sel, r_cfg.vin1);
         GT_SUB:  w_gfn = f_sub_mod(w_v0_sel, r_cfg.vin1);
         default: w_gfn = w_v0_sel;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_k_nxt        = r_k;
      w_round_nxt    = r_round;
      w_acc_nxt      = r_acc;
      w_t_nxt        = r_t;
      w_cfg_nxt      = r_cfg;
      w_vin0_nxt     = r_vin0;
      w_res_nxt      = r_res;
      w_gate_out_nxt = r_gate_out;
      w_ready_nxt    = r_ready;
      w_pulse_nxt    = 1'b0;
      w_done_nxt     = r_done;
      w_mul_start_c  = 1'b0;
      w_mul_abort_c  = 1'b0;
      w_mul_a_c      = w_t_cur;
      w_mul_b_c      = w_gfn;
      w_launch_c     = 1'b0;

      if (restart) begin
         w_mul_abort_c = 1'b1;
         w_state_nxt   = S_IDLE;
         w_k_nxt       = '0;
         w_acc_nxt     = F_NBITS'(1);
         w_round_nxt   = '0;
         w_done_nxt    = 1'b0;
         w_ready_nxt   = 1'b1;
         w_pulse_nxt   = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (en && !r_done) begin
                  w_cfg_nxt.precomp = precomp;
                  w_cfg_nxt.gt      = gate_type_e'(gate_type);
                  w_cfg_nxt.vin1    = vin1;
                  w_vin0_nxt        = vin0;
                  w_mul_start_c     = 1'b1;
                  w_mul_a_c         = r_acc;
                  w_mul_b_c         = w_f;
                  w_ready_nxt       = 1'b0;
                  w_state_nxt       = S_MUL_T;
               end
            end
            S_MUL_T: begin
               if (w_mul_valid) begin
                  w_t_nxt = w_mul_prod;
                  w_k_nxt = '0;
                  if (r_cfg.precomp) w_state_nxt = S_FIN;
                  else               w_launch_c  = 1'b1;
               end
            end
            S_GFN: begin
               if (w_mul_valid) begin
                  w_mul_start_c = 1'b1;
                  w_mul_a_c     = r_t;
                  w_mul_b_c     = w_mul_prod;
                  w_state_nxt   = S_OUT;
               end
            end
            S_OUT: begin
               if (w_mul_valid) begin
                  w_res_nxt[r_k] = w_mul_prod;
                  if (w_last) begin
                     w_state_nxt = S_FIN;
                  end else begin
                     w_k_nxt    = r_k + KW'(1);
                     w_launch_c = 1'b1;
                  end
               end
            end
            S_FIN: begin
               w_acc_nxt = r_t;
               if (!r_cfg.precomp) w_gate_out_nxt = r_res;
               w_round_nxt = r_round + RW'(1);
               w_done_nxt  = ((r_round + RW'(1)) == RW'(nidbits));
               w_ready_nxt = 1'b1;
               w_pulse_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase

         // Next point: mul gates need g_k first, others go straight to t*g_k
         if (w_launch_c) begin
            w_mul_start_c = 1'b1;
            if (r_cfg.gt == GT_MUL) begin
               w_mul_a_c   = w_v0_sel;
               w_mul_b_c   = r_cfg.vin1;
               w_state_nxt = S_GFN;
            end else begin
               w_state_nxt = S_OUT;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state    <= S_IDLE;
         r_k        <= '0;
         r_round    <= '0;
         r_acc      <= F_NBITS'(1);
         r_t        <= '0;
         r_cfg      <= '0;
         r_vin0     <= '0;
         r_res      <= '0;
         r_gate_out <= '0;
         r_ready    <= 1'b1;
         r_pulse    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_k        <= w_k_nxt;
         r_round    <= w_round_nxt;
         r_acc      <= w_acc_nxt;
         r_t        <= w_t_nxt;
         r_cfg      <= w_cfg_nxt;
         r_vin0     <= w_vin0_nxt;
         r_res      <= w_res_nxt;
         r_gate_out <= w_gate_out_nxt;
         r_ready    <= w_ready_nxt;
         r_pulse    <= w_pulse_nxt;
         r_done     <= w_done_nxt;
      end
   end

`ifdef PERGATE_COMPUTE_GEN_ERRFLAG_EN
   logic r_err, w_err_nxt;

   // Sticky: en while busy, while done, or alongside restart
   always_comb begin
      w_err_nxt = r_err;
      if (restart)                                    w_err_nxt = en;
      else if (en && ((r_state != S_IDLE) || r_done)) w_err_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) r_err <= 1'b0;
      else       r_err <= w_err_nxt;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign ready       = r_ready;
   assign ready_pulse = r_pulse;
   assign done        = r_done;
   assign gate_out    = r_gate_out;

endmodule

// File: tb/tb_pergate_compute_gen.sv
// Directed + randomized bench for pergate_compute_gen against a plain-arithmetic field model.
module tb_pergate_compute_gen;
   import pergate_compute_gen_pkg::*;

   localparam int unsigned NID = 3;
   localparam int unsigned NP  = 3;
   localparam int unsigned LAT = 2;
   localparam logic [NID-1:0] IDV = 3'b101;
`ifdef PERGATE_COMPUTE_GEN_ERRFLAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [63:0] Q = 64'(F_Q);

   logic                       clk = 1'b0;
   logic                       rstb, en, restart, precomp;
   logic [1:0]                 gate_type;
   logic [F_NBITS-1:0]         tau, m_tau_p1, vin1;
   logic [NP-1:0][F_NBITS-1:0] vin0;
   logic                       ready, ready_pulse, done, err;
   logic [NP-1:0][F_NBITS-1:0] gate_out;

   int          total, bad;
   logic [63:0] m_acc;
   int          m_round;
   bit          m_err;
   logic [63:0] m_go [NP];

   pergate_compute_gen #(.nidbits(NID), .id_vec(IDV), .npoints(NP), .mul_lat(LAT)) dut (
      .clk(clk), .rstb(rstb), .en(en), .restart(restart), .precomp(precomp),
      .gate_type(gate_type), .tau(tau), .m_tau_p1(m_tau_p1), .vin0(vin0), .vin1(vin1),
      .ready(ready), .ready_pulse(ready_pulse), .done(done), .err(err), .gate_out(gate_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mmul(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      p = 128'(a) * 128'(b);
      return 64'(p % 128'(Q));
   endfunction

   function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b);
      return (a + b) % Q;
   endfunction

   function automatic logic [63:0] msub(input logic [63:0] a, input logic [63:0] b);
      return (a + Q - b) % Q;
   endfunction

   function automatic logic [63:0] gfn(input logic [1:0] gt, input logic [63:0] a, input logic [63:0] b);
      case (gt)
         2'd0:    return madd(a, b);
         2'd1:    return mmul(a, b);
         2'd2:    return msub(a, b);
         default: return a;
      endcase
   endfunction

   function automatic logic [63:0] rnd_fe();
      logic [63:0] x;
      x = {$urandom, $urandom};
      return x % Q;
   endfunction

   function automatic logic [NP-1:0][F_NBITS-1:0] rnd_vec();
      logic [NP-1:0][F_NBITS-1:0] v;
      for (int k = 0; k < NP; k++) v[k] = F_NBITS'(rnd_fe());
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      for (int k = 0; k < NP; k++)
         chk($sformatf("%s_gate_out%0d", tag, k), 64'(gate_out[k]), m_go[k]);
      chk({tag, "_done"}, 64'(done), 64'(m_round >= NID));
      chk({tag, "_err"}, 64'(err), 64'(m_err));
   endtask

   task automatic run_round(input bit pre, input logic [1:0] gt, input logic [63:0] tv,
                            input logic [63:0] mv, input logic [NP-1:0][F_NBITS-1:0] v0,
                            input logic [63:0] v1, input bit busy_en);
      int          n, cyc;
      logic [63:0] f, t;
      f = IDV[m_round] ? tv : mv;
      t = mmul(m_acc, f);
      if (!pre)
         for (int k = 0; k < NP; k++) m_go[k] = mmul(t, gfn(gt, 64'(v0[k]), v1));
      n = pre ? 1 : ((gt == 2'd1) ? 1 + 2 * NP : 1 + NP);
      m_acc = t;
      m_round++;
      if (busy_en) m_err = m_err | ERR_EN;

      precomp = pre; gate_type = gt; tau = F_NBITS'(tv); m_tau_p1 = F_NBITS'(mv);
      vin0 = v0; vin1 = F_NBITS'(v1); en = 1'b1;
      tick();
      en = 1'b0;
      chk("busy_after_accept", 64'(ready), 64'(0));
      // inputs changing mid-round must not disturb the result
      precomp = ~pre; gate_type = ~gt; tau = F_NBITS'(rnd_fe()); m_tau_p1 = F_NBITS'(rnd_fe());
      vin0 = rnd_vec(); vin1 = F_NBITS'(rnd_fe());
      cyc = 0;
      while (ready !== 1'b1 && cyc < 200) begin
         if (busy_en) en = (cyc == 1);
         tick();
         cyc++;
      end
      en = 1'b0;
      chk("ready_rise_edge", 64'(cyc), 64'(n * LAT + 1));
      chk("ready_pulse_on_rise", 64'(ready_pulse), 64'(1));
      check_state("round");
      tick();
      chk("ready_pulse_one_cycle", 64'(ready_pulse), 64'(0));
      chk("ready_held", 64'(ready), 64'(1));
   endtask

   task automatic do_restart(input bit with_en);
      restart = 1'b1; en = with_en;
      tick();
      restart = 1'b0; en = 1'b0;
      m_acc = 64'd1; m_round = 0;
      m_err = with_en ? ERR_EN : 1'b0;
      chk("restart_ready", 64'(ready), 64'(1));
      chk("restart_pulse", 64'(ready_pulse), 64'(1));
      check_state("restart");
      tick();
      chk("restart_pulse_drop", 64'(ready_pulse), 64'(0));
      chk("restart_stays_idle", 64'(ready), 64'(1));
   endtask

   initial begin
      logic [NP-1:0][F_NBITS-1:0] v;
      logic [63:0]                tv;
      int                         stray;
      total = 0; bad = 0;
      rstb = 1'b0; en = 1'b0; restart = 1'b0; precomp = 1'b0; gate_type = 2'd0;
      tau = '0; m_tau_p1 = '0; vin0 = '0; vin1 = '0;
      m_acc = 64'd1; m_round = 0; m_err = 1'b0;
      for (int k = 0; k < NP; k++) m_go[k] = 64'd0;

      #12;
      chk("reset_ready", 64'(ready), 64'(1));
      chk("reset_pulse", 64'(ready_pulse), 64'(0));
      check_state("reset");
      rstb = 1'b1;
      stray = 0;
      repeat (20) begin
         tick();
         if (ready !== 1'b1 || ready_pulse !== 1'b0 || done !== 1'b0) stray++;
      end
      chk("idle_quiet_20", 64'(stray), 64'(0));
      check_state("idle");

      do_restart(1'b0);
      // round 0: precomp, tau selected -> acc = 5
      run_round(1'b1, 2'd0, 64'd5, rnd_fe(), rnd_vec(), rnd_fe(), 1'b0);
      // round 1: add, m_tau_p1 selected -> t = 35
      v[0] = 61'd1; v[1] = 61'd2; v[2] = 61'd3;
      run_round(1'b0, 2'd0, rnd_fe(), 64'd7, v, 64'd10, 1'b0);
      chk("add_k0_385", 64'(gate_out[0]), 64'd385);
      chk("add_k1_420", 64'(gate_out[1]), 64'd420);
      chk("add_k2_455", 64'(gate_out[2]), 64'd455);
      tv = rnd_fe();
      run_round(1'b0, 2'($urandom_range(0, 3)), tv, msub(64'd1, tv), rnd_vec(), rnd_fe(), 1'b1);
      chk("done_after_3", 64'(done), 64'(1));

      // en while done is ignored
      en = 1'b1;
      tick();
      en = 1'b0;
      m_err = m_err | ERR_EN;
      chk("done_en_ready", 64'(ready), 64'(1));
      chk("done_en_pulse", 64'(ready_pulse), 64'(0));
      repeat (4) tick();
      chk("done_en_still_ready", 64'(ready), 64'(1));
      check_state("done_en");

      do_restart(1'b1);
      do_restart(1'b0);

      // mul wrap with t = 1
      v[0] = F_NBITS'(Q - 64'd1); v[1] = 61'd2; v[2] = 61'd0;
      run_round(1'b0, 2'd1, 64'd1, rnd_fe(), v, Q - 64'd1, 1'b0);
      chk("mul_wrap_k0", 64'(gate_out[0]), 64'd1);
      chk("mul_wrap_k1", 64'(gate_out[1]), Q - 64'd2);
      chk("mul_wrap_k2", 64'(gate_out[2]), 64'd0);
      v = rnd_vec(); v[0] = 61'd2;
      run_round(1'b0, 2'd2, rnd_fe(), 64'd1, v, 64'd3, 1'b0);
      chk("sub_neg_k0", 64'(gate_out[0]), Q - 64'd1);

      // restart at cycle 4 of an evaluation round
      precomp = 1'b0; gate_type = 2'd1; tau = F_NBITS'(rnd_fe()); vin0 = rnd_vec();
      vin1 = F_NBITS'(rnd_fe()); en = 1'b1;
      tick();
      en = 1'b0;
      repeat (3) tick();
      chk("midround_busy", 64'(ready), 64'(0));
      do_restart(1'b0);
      run_round(1'b1, 2'd0, 64'd9, rnd_fe(), rnd_vec(), rnd_fe(), 1'b0);
      v = rnd_vec();
      run_round(1'b0, 2'd3, rnd_fe(), 64'd1, v, rnd_fe(), 1'b0);
      chk("acc9_pass_k0", 64'(gate_out[0]), mmul(64'd9, 64'(v[0])));

      // randomized full sequences
      repeat (6) begin
         do_restart(1'b0);
         for (int r = 0; r < NID; r++) begin
            tv = rnd_fe();
            run_round(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), tv,
                      msub(64'd1, tv), rnd_vec(), rnd_fe(), 1'($urandom_range(0, 1)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
